// File: rtl/fpu_round_pkg.sv
// Shared types for the FPU mantissa rounding pipeline: rounding-mode
// encoding and bit positions inside the {guard, round, sticky} field.
package fpu_round_pkg;

  typedef enum logic [2:0] {
    RND_RNE = 3'd0,
    RND_RTZ = 3'd1,
    RND_RDN = 3'd2,
    RND_RUP = 3'd3,
    RND_RMM = 3'd4
  } rnd_mode_e;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  function automatic logic grs_any(input logic [2:0] grs);
    return grs[GRS_G] | grs[GRS_R] | grs[GRS_S];
  endfunction

endpackage

// File: rtl/man_round_decide.sv
// Combinational round-increment decision for one mantissa, given sign,
// mantissa LSB, {guard, round, sticky} and rounding mode.
module man_round_decide
  import fpu_round_pkg::*;
(
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic [2:0] i_grs,
  input  rnd_mode_e  i_mode,
  output logic       o_inc
);

  logic w_g;
  logic w_any;

  assign w_g   = i_grs[GRS_G];
  assign w_any = grs_any(i_grs);

  always_comb begin
    o_inc = 1'b0;
    case (i_mode)
      RND_RTZ: o_inc = 1'b0;
      RND_RDN: o_inc = i_sign & w_any;
      RND_RUP: o_inc = !i_sign & w_any;
      RND_RMM: o_inc = w_g;
      // RNE and the unused encodings: ties go to the even mantissa
      default: o_inc = w_g & (i_grs[GRS_R] | i_grs[GRS_S] | i_lsb);
    endcase
  end

endmodule

// File: rtl/man_round_pipe.sv
// Two-stage valid/ready IEEE-754 mantissa rounding unit.
// Optional macro FPU_ROUND_SAT_EN: every overflow saturates to max finite.
module man_round_pipe
  import fpu_round_pkg::*;
#(
  parameter int SIZE_MAN = 24,
  parameter int SIZE_EXP = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MAN-1:0] i_man,
  input  logic [2:0]          i_grs,
  input  logic [2:0]          i_rnd_mode,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_sign,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_ov_flow,
  output logic                o_inexact
);

  localparam logic [SIZE_EXP-1:0] EXP_ONES = {SIZE_EXP{1'b1}};
  localparam logic [SIZE_EXP-1:0] EXP_MAX  = {{(SIZE_EXP-1){1'b1}}, 1'b0};
  localparam logic [SIZE_MAN-1:0] MAN_ONES = {SIZE_MAN{1'b1}};
  localparam logic [SIZE_MAN-1:0] MAN_HID  = {1'b1, {(SIZE_MAN-1){1'b0}}};

  // Overflow goes to infinity only when the mode rounds away from zero
  // in the operand's direction; otherwise it clamps to max finite.
  function automatic logic ovf_to_inf(input rnd_mode_e mode, input logic sign);
`ifdef FPU_ROUND_SAT_EN
    ovf_to_inf = 1'b0;
    if (mode == RND_RTZ && sign) ovf_to_inf = 1'b0;
`else
    case (mode)
      RND_RTZ: ovf_to_inf = 1'b0;
      RND_RDN: ovf_to_inf = sign;
      RND_RUP: ovf_to_inf = !sign;
      default: ovf_to_inf = 1'b1;
    endcase
`endif
  endfunction

  logic                w_s2_open;
  logic                w_s2_load;
  logic                w_accept;
  logic                w_special_p0;
  logic                w_inc_raw_p0;
  logic                w_inc_p0;
  rnd_mode_e           w_mode_p0;

  logic                r_vld_p1;
  logic                r_sign_p1;
  logic [SIZE_EXP-1:0] r_exp_p1;
  logic [SIZE_MAN-1:0] r_man_p1;
  logic [2:0]          r_grs_p1;
  rnd_mode_e           r_mode_p1;
  logic                r_inc_p1;
  logic                r_special_p1;

  logic [SIZE_MAN:0]   w_sum_p1;
  logic                w_carry_p1;
  logic                w_ovf_p1;
  logic [SIZE_EXP-1:0] w_exp_inc_p1;
  logic [SIZE_EXP-1:0] w_exp_p1;
  logic [SIZE_MAN-1:0] w_man_p1;
  logic                w_inex_p1;

  logic                r_vld_p2;
  logic                r_sign_p2;
  logic [SIZE_EXP-1:0] r_exp_p2;
  logic [SIZE_MAN-1:0] r_man_p2;
  logic                r_ov_p2;
  logic                r_inex_p2;

  assign w_s2_open = !r_vld_p2 | i_ready;
  assign w_s2_load = r_vld_p1 & w_s2_open;
  assign o_ready   = !r_vld_p1 | w_s2_open;
  assign w_accept  = i_valid & o_ready;

  // ---- stage 0 -> 1: capture operand, decide increment ----
  assign w_special_p0 = (i_exp == EXP_ONES);
  assign w_mode_p0    = rnd_mode_e'(i_rnd_mode);

  man_round_decide u_decide (
    .i_sign (i_sign),
    .i_lsb  (i_man[0]),
    .i_grs  (i_grs),
    .i_mode (w_mode_p0),
    .o_inc  (w_inc_raw_p0)
  );

  assign w_inc_p0 = w_inc_raw_p0 & !w_special_p0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (o_ready) begin
      r_vld_p1 <= i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_sign_p1    <= i_sign;
      r_exp_p1     <= i_exp;
      r_man_p1     <= i_man;
      r_grs_p1     <= i_grs;
      r_mode_p1    <= w_mode_p0;
      r_inc_p1     <= w_inc_p0;
      r_special_p1 <= w_special_p0;
    end
  end

  // ---- stage 1 -> 2: increment, renormalise, resolve overflow ----
  assign w_sum_p1     = {1'b0, r_man_p1} + {{SIZE_MAN{1'b0}}, r_inc_p1};
  assign w_carry_p1   = w_sum_p1[SIZE_MAN];
  assign w_exp_inc_p1 = r_exp_p1 + SIZE_EXP'(1);
  assign w_ovf_p1     = w_carry_p1 & (r_exp_p1 == EXP_MAX);

  always_comb begin
    w_exp_p1  = r_exp_p1;
    w_man_p1  = w_sum_p1[SIZE_MAN-1:0];
    w_inex_p1 = grs_any(r_grs_p1);
    if (r_special_p1) begin
      w_man_p1  = r_man_p1;
      w_inex_p1 = 1'b0;
    end else if (w_ovf_p1) begin
      if (ovf_to_inf(r_mode_p1, r_sign_p1)) begin
        w_exp_p1 = EXP_ONES;
        w_man_p1 = MAN_HID;
      end else begin
        w_exp_p1 = EXP_MAX;
        w_man_p1 = MAN_ONES;
      end
    end else if (w_carry_p1) begin
      w_exp_p1 = w_exp_inc_p1;
      w_man_p1 = MAN_HID;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p2  <= 1'b0;
      r_sign_p2 <= 1'b0;
      r_exp_p2  <= '0;
      r_man_p2  <= '0;
      r_ov_p2   <= 1'b0;
      r_inex_p2 <= 1'b0;
    end else begin
      if (w_s2_open) r_vld_p2 <= r_vld_p1;
      if (w_s2_load) begin
        r_sign_p2 <= r_sign_p1;
        r_exp_p2  <= w_exp_p1;
        r_man_p2  <= w_man_p1;
        r_ov_p2   <= w_ovf_p1;
        r_inex_p2 <= w_inex_p1;
      end
    end
  end

  assign o_valid   = r_vld_p2;
  assign o_sign    = r_sign_p2;
  assign o_exp     = r_exp_p2;
  assign o_man     = r_man_p2;
  assign o_ov_flow = r_ov_p2;
  assign o_inexact = r_inex_p2;

endmodule

// File: tb/tb_man_round_pipe.sv
// Directed scoreboard bench for man_round_pipe (SIZE_MAN=24, SIZE_EXP=8).
module tb_man_round_pipe;
  import fpu_round_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] man;
    logic        ov;
    logic        inex;
  } res_t;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exp = '0;
  logic [23:0] i_man = '0;
  logic [2:0]  i_grs = '0;
  logic [2:0]  i_rnd_mode = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sign;
  logic [7:0]  o_exp;
  logic [23:0] o_man;
  logic        o_ov_flow;
  logic        o_inexact;

  int   errors = 0;
  int   checks = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   rdy_low = 0;
  res_t q[$];
  res_t held;
  logic held_vld = 1'b0;

  always #5 clk = ~clk;

  man_round_pipe #(.SIZE_MAN(24), .SIZE_EXP(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_grs(i_grs),
    .i_rnd_mode(i_rnd_mode), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_man(o_man), .o_ov_flow(o_ov_flow),
    .o_inexact(o_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t R(input logic s, input logic [7:0] e, input logic [23:0] m,
                             input logic ov, input logic inex);
    res_t r;
    r.sign = s; r.exp = e; r.man = m; r.ov = ov; r.inex = inex;
    return r;
  endfunction

  function automatic res_t model(input logic s, input logic [7:0] e, input logic [23:0] m,
                                 input logic [2:0] grs, input logic [2:0] md);
    res_t r;
    logic inc;
    logic any;
    logic inf;
    any = |grs;
    r = R(s, e, m, 1'b0, 1'b0);
    if (e == 8'hFF) return r;
    r.inex = any;
    case (md)
      3'd1:    inc = 1'b0;
      3'd2:    inc = s & any;
      3'd3:    inc = !s & any;
      3'd4:    inc = grs[2];
      default: inc = grs[2] & (grs[1] | grs[0] | m[0]);
    endcase
    if (inc) begin
      if (m == 24'hFFFFFF) begin
        if (e == 8'hFE) begin
          r.ov = 1'b1;
          inf = !(md == 3'd1 || (md == 3'd2 && !s) || (md == 3'd3 && s));
`ifdef FPU_ROUND_SAT_EN
          inf = 1'b0;
`endif
          r.exp = inf ? 8'hFF : 8'hFE;
          r.man = inf ? 24'h800000 : 24'hFFFFFF;
        end else begin
          r.exp = e + 8'd1;
          r.man = 24'h800000;
        end
      end else begin
        r.man = m + 24'd1;
      end
    end
    return r;
  endfunction

  // Scoreboard/monitor: sample on the falling edge, between active edges.
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (held_vld && o_valid)
        chk("stall_stable", 64'({o_sign, o_exp, o_man, o_ov_flow, o_inexact}), 64'(held));
      held_vld = o_valid && !i_ready;
      held = R(o_sign, o_exp, o_man, o_ov_flow, o_inexact);
      if (o_valid && i_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out", 64'(o_valid), 64'(0));
        end else begin
          res_t e;
          e = q.pop_front();
          chk("result", 64'({o_sign, o_exp, o_man, o_ov_flow, o_inexact}), 64'(e));
        end
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic tick();
    if (rdy_low > 0) begin
      rdy_low--;
      if (rdy_low == 0) i_ready = 1'b1;
    end
  endtask

  task automatic push_beat(input logic s, input logic [7:0] e, input logic [23:0] m,
                           input logic [2:0] g, input logic [2:0] md, input res_t exp);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    i_valid = 1'b1; i_sign = s; i_exp = e; i_man = m; i_grs = g; i_rnd_mode = md;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      tick();
      n++;
    end
    i_valid = 1'b0;
    chk("accept_timeout", 64'(acc), 64'(1));
    if (acc) begin
      q.push_back(exp);
      n_in++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || o_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(n < 100), 64'(1));
  endtask

  initial begin
    res_t ov_inf, ov_max;
    ov_max = R(1'b0, 8'hFE, 24'hFFFFFF, 1'b1, 1'b1);
`ifdef FPU_ROUND_SAT_EN
    ov_inf = ov_max;
`else
    ov_inf = R(1'b0, 8'hFF, 24'h800000, 1'b1, 1'b1);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_data", 64'({o_sign, o_exp, o_man, o_ov_flow, o_inexact}), 64'(0));
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(o_ready), 64'(1));
    chk("rst_valid_after", 64'(o_valid), 64'(0));

    // Directed rounding cases, back-to-back with i_ready high
    push_beat(0, 8'h80, 24'hC00000, 3'b100, RND_RNE, R(0, 8'h80, 24'hC00000, 0, 1));
    push_beat(0, 8'h80, 24'hC00001, 3'b100, RND_RNE, R(0, 8'h80, 24'hC00002, 0, 1));
    push_beat(0, 8'hFE, 24'hFFFFFF, 3'b111, RND_RNE, ov_inf);
    push_beat(0, 8'hFE, 24'hFFFFFF, 3'b111, RND_RTZ, R(0, 8'hFE, 24'hFFFFFF, 0, 1));
    push_beat(0, 8'hFE, 24'hFFFFFF, 3'b111, RND_RUP, ov_inf);
    push_beat(1, 8'hFE, 24'hFFFFFF, 3'b111, RND_RDN,
              R(1, ov_inf.exp, ov_inf.man, 1, 1));
    push_beat(0, 8'h80, 24'h800000, 3'b001, RND_RUP, R(0, 8'h80, 24'h800001, 0, 1));
    push_beat(0, 8'h80, 24'h800000, 3'b001, RND_RDN, R(0, 8'h80, 24'h800000, 0, 1));
    push_beat(1, 8'h80, 24'h800000, 3'b001, RND_RDN, R(1, 8'h80, 24'h800001, 0, 1));
    push_beat(0, 8'h80, 24'h800000, 3'b100, RND_RMM, R(0, 8'h80, 24'h800001, 0, 1));
    push_beat(0, 8'hFF, 24'hC00000, 3'b111, RND_RUP, R(0, 8'hFF, 24'hC00000, 0, 0));
    push_beat(0, 8'h40, 24'h800001, 3'b100, 3'd7,    R(0, 8'h40, 24'h800002, 0, 1));
    push_beat(0, 8'h00, 24'hFFFFFF, 3'b100, RND_RNE, R(0, 8'h01, 24'h800000, 0, 1));
    push_beat(1, 8'h80, 24'hC00001, 3'b100, RND_RTZ, R(1, 8'h80, 24'hC00001, 0, 1));
    push_beat(0, 8'h80, 24'h800000, 3'b000, RND_RUP, R(0, 8'h80, 24'h800000, 0, 0));
    drain("drain_directed");

    // Carry renormalise and two-cycle latency
    push_beat(0, 8'h80, 24'hFFFFFF, 3'b110, RND_RNE, R(0, 8'h81, 24'h800000, 0, 1));
    chk("lat_cycle1", 64'(o_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("lat_cycle2", 64'(o_valid), 64'(1));
    drain("drain_latency");

    // Backpressure: i_ready low for 3 cycles while streaming 5 beats
    i_ready = 1'b0;
    rdy_low = 3;
    for (int i = 0; i < 5; i++) begin
      logic [23:0] m;
      logic [2:0]  g;
      logic [2:0]  md;
      m  = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
      g  = 3'($urandom_range(0, 7));
      md = 3'(i);
      push_beat(i[0], 8'(8'h10 + i), m, g, md, model(i[0], 8'(8'h10 + i), m, g, md));
      if (i == 1) chk("bp_ready_low", 64'(o_ready), 64'(0));
    end
    drain("drain_bp");

    // Reset with two beats held in the pipe
    i_ready = 1'b0;
    push_beat(0, 8'h20, 24'h900000, 3'b100, RND_RMM, R(0, 8'h20, 24'h900001, 0, 1));
    push_beat(1, 8'h21, 24'hA00000, 3'b001, RND_RDN, R(1, 8'h21, 24'hA00001, 0, 1));
    i_rst_n = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    q.delete();
    n_in -= 2;
    chk("midrst_valid", 64'(o_valid), 64'(0));
    chk("midrst_data", 64'({o_sign, o_exp, o_man, o_ov_flow, o_inexact}), 64'(0));
    chk("midrst_ready", 64'(o_ready), 64'(1));
    i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    push_beat(0, 8'h30, 24'h800003, 3'b100, RND_RNE, R(0, 8'h30, 24'h800004, 0, 1));
    drain("drain_after_rst");

    chk("queue_empty", 64'(q.size()), 64'(0));
    chk("beat_count", 64'(n_out), 64'(n_in));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/man_round_pipe.md
Name: man_round_pipe

Overview:
- Pipelined, multi-mode IEEE-754 mantissa rounding unit.
- Takes a normalised mantissa, its exponent, sign and guard/round/sticky bits.
- Returns the rounded, renormalised mantissa and exponent, with overflow and inexact flags.
- Sits after the FPU_MUL/FPU_ADD normaliser in the FFT datapath; 2-stage valid/ready pipeline, one result per cycle.

Parameters:
- SIZE_MAN, 24: mantissa width including hidden bit (MSB).
- SIZE_EXP, 8: biased exponent width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept input this cycle
- i_sign  in  1  operand sign
- i_exp  in  SIZE_EXP  biased exponent
- i_man  in  SIZE_MAN  normalised mantissa (MSB = hidden 1)
- i_grs  in  3  {guard, round, sticky}
- i_rnd_mode  in  3  rounding mode, sampled with i_valid
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_sign  out  1  result sign
- o_exp  out  SIZE_EXP  result exponent
- o_man  out  SIZE_MAN  result mantissa
- o_ov_flow  out  1  exponent overflow occurred
- o_inexact  out  1  any of G/R/S set

Behaviour:
- One clock, i_clk. Reset i_rst_n is synchronous and active-low.
- Reset:
  - s1_valid and s2_valid clear; in-flight beats are dropped, including on reset mid-operation.
  - o_valid=0 and all data outputs =0.
  - o_ready=1 in the first cycle after reset release.
- Handshake:
  - Input accepted when i_valid & o_ready.
  - Output transferred when o_valid & i_ready.
  - o_ready = !s1_valid | (!s2_valid | i_ready).
  - Stage 2 loads when s1_valid & (!s2_valid | i_ready).
  - While o_valid & !i_ready, all outputs hold stable.
  - Latency: exactly 2 cycles from accept to o_valid. Throughput: 1 beat per cycle with i_ready held high.
- Stage 1 registers sign/exp/man/grs/mode and computes the increment bit inc:
  - 000 RNE: G & (R | S | man[0])
  - 001 RTZ: 0
  - 010 RDN: sign & (G | R | S)
  - 011 RUP: !sign & (G | R | S)
  - 100 RMM: G
  - 101..111: treated as RNE.
- Stage 2 adds inc to man:
  - Carry out (man all ones and inc=1): o_man = {1'b1, zeros}, o_exp = exp+1.
  - Otherwise o_exp = exp.
  - o_inexact = |grs.
- Overflow:
  - Raised when the carry makes exp+1 = all ones, or the input exp is all ones-1 with a carry.
  - o_ov_flow=1 and the result is IEEE overflow per mode.
  - RNE/RMM: infinity (exp all ones, man = {1'b1, zeros}).
  - RTZ: max finite (exp = all ones-1, man all ones).
  - RDN: -inf if sign=1, else max finite.
  - RUP: +inf if sign=0, else max finite.
- Special input: i_exp all ones (inf/NaN) passes through unchanged; inc forced 0, o_inexact=0, o_ov_flow=0.
- Zero/denormal input (exp=0): rounded as above. A carry into the hidden bit yields exp=1 with no special handling.

Optional Feature:
- Macro: FPU_ROUND_SAT_EN.
- Defined: every overflow saturates to max finite in all modes; o_ov_flow still asserts.
- Undefined: IEEE per-mode overflow results as above.

Decomposition:
- Shared package fpu_round_pkg:
  - typedef enum logic [2:0] rnd_mode_e {RND_RNE, RND_RTZ, RND_RDN, RND_RUP, RND_RMM}.
  - GRS bit-index localparams.
- Combinational sub-module man_round_decide(sign, lsb, grs, mode -> inc), instantiated in stage 1.

Test Plan (SIZE_MAN=24, SIZE_EXP=8):
- RNE tie, even: man=0xC00000, exp=0x80, grs=100 -> o_man=0xC00000, o_exp=0x80, o_inexact=1. Same with man=0xC00001 -> o_man=0xC00002.
- Carry renormalise: man=0xFFFFFF, exp=0x80, grs=110, RNE -> o_man=0x800000, o_exp=0x81, o_ov_flow=0, o_valid exactly 2 cycles after accept.
- Overflow: man=0xFFFFFF, exp=0xFE, grs=111, sign=0.
  - RNE -> exp=0xFF, man=0x800000, o_ov_flow=1.
  - RTZ -> exp=0xFE, man=0xFFFFFF, o_ov_flow=0.
  - Rerun with FPU_ROUND_SAT_EN and RUP -> exp=0xFE, man=0xFFFFFF, o_ov_flow=1.
- Directed modes: grs=001, man=0x800000.
  - RUP with sign=0 -> 0x800001.
  - RDN with sign=0 -> 0x800000.
  - RDN with sign=1 -> 0x800001.
- Backpressure: stream 5 beats back-to-back with i_ready low for 3 cycles -> o_ready drops after 2 beats are held; outputs stable; order preserved; no loss or duplication.
- Reset mid-stream: assert i_rst_n=0 for one cycle with 2 beats in flight -> next cycle o_valid=0, data outputs 0, o_ready=1; in-flight beats never appear.
